button_event_detect: RTL and testbench
======================================

# button_event_detect

Multi-channel pushbutton front end for the board's user inputs. Each of `N_CH` raw button pins is synchronised, sampled on a shared divided tick, debounced by a consecutive-sample counter, and turned into single-cycle press, release and long-press event pulses plus a clean debounced level. It replaces per-button single-channel detector chains and drives the control FSMs directly in the system `clk` domain, with no derived clock.

## Interface
- `N_CH`, 4: number of independent button channels (≥1).
- `TICK_DIV`, 50_000: `clk` cycles per sample tick (≥1; 1 = sample every cycle).
- `DEB_SAMPLES`, 4: consecutive differing samples needed to flip the debounced level (≥1).
- `HOLD_TICKS`, 1000: ticks a press must be held before `long_pulse` fires (≥1).
- `ACTIVE_LOW`, {N_CH{1'b0}}: per-channel bit; 1 = input is inverted before synchronisation.

Ports:
- `clk` input 1: single system clock; every flop is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn_in` input N_CH: raw, asynchronous button pins.
- `btn_level` output N_CH: debounced, polarity-corrected level; 1 = pressed.
- `press_pulse` output N_CH: one-cycle pulse on a debounced 0→1 transition.
- `release_pulse` output N_CH: one-cycle pulse on a debounced 1→0 transition.
- `long_pulse` output N_CH: one-cycle pulse when a press has been held `HOLD_TICKS` ticks.

## Operation
- Polarity: `p[i] = btn_in[i] ^ ACTIVE_LOW[i]`, fed into a 2-flop synchroniser per channel (`s2[i]`).
- Tick generator: counter `0..TICK_DIV-1`, `$clog2(TICK_DIV)` bits, wraps to 0; `tick` is high for the one cycle the counter equals `TICK_DIV-1`. It is shared by all channels.
- Debounce per channel, evaluated only on `tick`:
  - If `s2 == btn_level`, then `deb_cnt <= 0`.
  - Else if `deb_cnt == DEB_SAMPLES-1`, then `btn_level` toggles and `deb_cnt <= 0`.
  - Else `deb_cnt <= deb_cnt + 1`.
  - A single agreeing sample restarts the count, so the level flips only on the `DEB_SAMPLES`-th consecutive differing tick.
- Edge pulses are registered at the same edge that updates `btn_level`. `press_pulse` is high exactly in the first cycle `btn_level` reads 1; `release_pulse` is high in the first cycle it reads 0.
- Long press, per-channel `hold_cnt` (`$clog2(HOLD_TICKS+1)` bits):
  - Cleared while `btn_level == 0` and at the press edge.
  - While `btn_level == 1`, on each tick with `hold_cnt < HOLD_TICKS`, it increments. The increment reaching `HOLD_TICKS` asserts `long_pulse` for one cycle.
  - Once at `HOLD_TICKS` it saturates, so there is no repeat until release.
  - The flip tick itself is not counted.
- Simultaneous events: if the tick that would complete the hold count also flips `btn_level` to 0, the release wins. `release_pulse` fires, `long_pulse` does not, and `hold_cnt` clears.
- Channels are fully independent; any combination of pulse bits may be high in the same cycle.

## Timing
- Reset values: all outputs are 0. Synchronisers, tick counter, `deb_cnt`, `hold_cnt` and `btn_level` are all 0, i.e. every channel starts released.
- Reset mid-operation: outputs clear immediately (asynchronously) and no `release_pulse` is emitted. If a button is still held after `rst` deasserts, it yields a normal `press_pulse` after debounce.
- Latency from a clean, stable change on `btn_in`: 2 cycles of synchronisation, then `DEB_SAMPLES` ticks. The flip appears 1 cycle after the deciding tick. Worst case is `3 + DEB_SAMPLES*TICK_DIV` cycles; best case is `2 + (DEB_SAMPLES-1)*TICK_DIV + 1`.
- `long_pulse` fires exactly `HOLD_TICKS*TICK_DIV` cycles after `press_pulse`, since ticks are periodic.
- Every pulse output is exactly 1 cycle wide. At most one `press_pulse` and one `release_pulse` occur per debounced transition.

## Test plan
Bench parameters: `N_CH=2`, `TICK_DIV=4`, `DEB_SAMPLES=3`, `HOLD_TICKS=5`, `ACTIVE_LOW=2'b10`.

- **Reset:** assert `rst` with `btn_in=2'b10` -> all outputs are 0 during and after reset. Channel 1 is idle-high with active-low polarity, so it stays released with no pulses.
- **Clean press:** `btn_in[0]` held 0→1 -> a single `press_pulse[0]` arrives within 15 cycles. `btn_level[0]=1` in the same cycle and stays 1.
- **Bounce rejection:** `btn_in[0]` toggled with 8-cycle (2-tick) high periods and 1-tick lows, repeated 10 times -> `btn_level[0]` stays 0 and no pulses occur.
- **Long press and release:** hold `btn_in[0]` -> `long_pulse[0]` fires exactly 20 cycles after `press_pulse[0]`. Holding a further 100 cycles produces no more pulses. Releasing gives one `release_pulse[0]` within 15 cycles.
- **Release beats long:** release timed so the 3rd differing sample lands on the 5th hold tick -> `release_pulse[0]` fires and `long_pulse[0]` never does.
- **Reset mid-hold, plus second channel:** assert `rst` while `btn_level[0]=1`, and drive `btn_in[1]` 1→0 at the same time -> no `release_pulse[0]`. After `rst` deasserts, `press_pulse[0]` and `press_pulse[1]` each fire exactly once.

Source files
------------

// File: rtl/button_event_detect.sv
`default_nettype none
// ============================================================================
// Module      : button_event_detect
// Description : N-channel button front end: synchroniser, tick-sampled
//               debounce, press/release/long-press single-cycle event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_detect #(
    parameter int              N_CH        = 4,
    parameter int              TICK_DIV    = 50_000,
    parameter int              DEB_SAMPLES = 4,
    parameter int              HOLD_TICKS  = 1000,
    parameter logic [N_CH-1:0] ACTIVE_LOW  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W  = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  C_DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX  = HOLD_W'(HOLD_TICKS);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    logic [N_CH-1:0]   pol;
    logic [N_CH-1:0]   sync1_q, sync2_q;
    logic [N_CH-1:0]   level_q, level_d;
    logic [N_CH-1:0]   press_q, press_d;
    logic [N_CH-1:0]   release_q, release_d;
    logic [N_CH-1:0]   long_q, long_d;
    logic [N_CH-1:0]   flip;
    logic [DEB_W-1:0]  deb_cnt_q  [N_CH];
    logic [DEB_W-1:0]  deb_cnt_d  [N_CH];
    logic [HOLD_W-1:0] hold_cnt_q [N_CH];
    logic [HOLD_W-1:0] hold_cnt_d [N_CH];

    assign pol  = btn_in ^ ACTIVE_LOW;
    assign tick = (tick_cnt_q == C_TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        level_d    = level_q;
        press_d    = '0;
        release_d  = '0;
        long_d     = '0;
        flip       = '0;
        for (int i = 0; i < N_CH; i++) begin
            deb_cnt_d[i]  = deb_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];

            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == C_DEB_LAST) begin
                    flip[i]      = 1'b1;
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end

            if (flip[i]) begin
                level_d[i]   = ~level_q[i];
                press_d[i]   = ~level_q[i];
                release_d[i] = level_q[i];
            end

            // A release on the completing tick wins over the long-press event.
            if (!level_q[i] || flip[i]) begin
                hold_cnt_d[i] = '0;
            end else if (tick && (hold_cnt_q[i] < C_HOLD_MAX)) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
                long_d[i]     = (hold_cnt_d[i] == C_HOLD_MAX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= pol;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_detect
// Description : Directed self-checking bench for button_event_detect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in = 2'b10;
    logic [1:0] btn_level, press_pulse, release_pulse, long_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int press_n [2] = '{0, 0};
    int rel_n   [2] = '{0, 0};
    int long_n  [2] = '{0, 0};
    int sp [2];
    int sr [2];
    int sl [2];
    int n;
    bit seen;

    button_event_detect #(
        .N_CH        (2),
        .TICK_DIV    (4),
        .DEB_SAMPLES (3),
        .HOLD_TICKS  (5),
        .ACTIVE_LOW  (2'b10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (press_pulse[c])   press_n[c]++;
            if (release_pulse[c]) rel_n[c]++;
            if (long_pulse[c])    long_n[c]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 0 = press, 1 = release, 2 = long
    task automatic wait_pulse(input int kind, input int ch, input int limit,
                              output int cyc, output bit hit);
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < limit) begin
            @(negedge clk);
            cyc++;
            case (kind)
                0:       hit = press_pulse[ch];
                1:       hit = release_pulse[ch];
                default: hit = long_pulse[ch];
            endcase
        end
    endtask

    task automatic snap();
        for (int c = 0; c < 2; c++) begin
            sp[c] = press_n[c];
            sr[c] = rel_n[c];
            sl[c] = long_n[c];
        end
    endtask

    initial begin
        // Reset with channel 1 idle-high (released, active-low)
        repeat (3) @(negedge clk);
        chk("rst_level",   btn_level,     0);
        chk("rst_press",   press_pulse,   0);
        chk("rst_release", release_pulse, 0);
        chk("rst_long",    long_pulse,    0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_level",  btn_level, 0);
        chk("idle_pulses", press_n[0] + press_n[1] + rel_n[0] + rel_n[1]
                           + long_n[0] + long_n[1], 0);

        // Clean press, long press timing, then release
        snap();
        btn_in[0] = 1'b1;
        wait_pulse(0, 0, 15, n, seen);
        chk("press0_seen",  seen, 1);
        chk("press0_level", btn_level[0], 1);
        wait_pulse(2, 0, 30, n, seen);
        chk("long0_seen",  seen, 1);
        chk("long0_delay", n, 20);
        repeat (100) @(negedge clk);
        chk("hold_level",  btn_level[0], 1);
        chk("hold_press",  press_n[0] - sp[0], 1);
        chk("hold_long",   long_n[0] - sl[0], 1);
        chk("hold_rel",    rel_n[0] - sr[0], 0);
        btn_in[0] = 1'b0;
        wait_pulse(1, 0, 15, n, seen);
        chk("rel0_seen",  seen, 1);
        chk("rel0_level", btn_level[0], 0);
        repeat (5) @(negedge clk);
        chk("rel0_count", rel_n[0] - sr[0], 1);

        // Bounce: 8-cycle highs, 4-cycle lows
        snap();
        for (int k = 0; k < 10; k++) begin
            btn_in[0] = 1'b1;
            repeat (8) @(negedge clk);
            btn_in[0] = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("bounce_level", btn_level[0], 0);
        chk("bounce_press", press_n[0] - sp[0], 0);
        chk("bounce_rel",   rel_n[0] - sr[0], 0);

        // Release completes on the same tick as the 5th hold tick
        snap();
        btn_in[0] = 1'b1;
        wait_pulse(0, 0, 15, n, seen);
        chk("rbl_press_seen", seen, 1);
        repeat (9) @(negedge clk);
        btn_in[0] = 1'b0;
        wait_pulse(1, 0, 30, n, seen);
        chk("rbl_rel_seen",  seen, 1);
        chk("rbl_rel_delay", n, 11);
        repeat (30) @(negedge clk);
        chk("rbl_long", long_n[0] - sl[0], 0);
        chk("rbl_rel",  rel_n[0] - sr[0], 1);

        // Reset while channel 0 is held; channel 1 pressed concurrently
        btn_in[0] = 1'b1;
        wait_pulse(0, 0, 15, n, seen);
        chk("mid_press_seen", seen, 1);
        repeat (2) @(negedge clk);
        snap();
        rst       = 1'b1;
        btn_in[1] = 1'b0;
        #1;
        chk("mid_rst_level", btn_level, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_rel0",   rel_n[0] - sr[0], 0);
        chk("mid_rel1",   rel_n[1] - sr[1], 0);
        chk("mid_press0", press_n[0] - sp[0], 1);
        chk("mid_press1", press_n[1] - sp[1], 1);
        chk("mid_level",  btn_level, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
